axi_read_arbiter: RTL and testbench
===================================

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameters SHALL be: none; all widths come from AXI_define (ID 4, ADDR 32, DATA 32, LEN 4, SIZE 3, BURST 2).
REQ-002 ACLK  in  1  single clock; all logic on rising edge.
REQ-003 ARESETn  in  1  reset, synchronous, active-low.
REQ-004 ARID_M{0,1}, ARADDR_M{0,1}, ARLEN_M{0,1}, ARSIZE_M{0,1}, ARBURST_M{0,1}  in  4/32/4/3/2  master read-address payloads.
REQ-005 ARVALID_M{0,1}  in  1  master read requests.
REQ-006 ARREADY_M{0,1}  out  1  per-master address accept.
REQ-007 RID_M{0,1}, RDATA_M{0,1}, RRESP_M{0,1}, RLAST_M{0,1}, RVALID_M{0,1}  out  4/32/2/1/1  routed read data.
REQ-008 RREADY_M{0,1}  in  1  master data accept.
REQ-009 ARID_S  out  8  {4'b master index, master ARID}; ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  out  32/4/3/2; ARVALID_S  out  1; ARREADY_S  in  1.
REQ-010 RID_S  in  8; RDATA_S  in  32; RRESP_S  in  2; RLAST_S  in  1; RVALID_S  in  1; RREADY_S  out  1.

Function
REQ-011 FSM states SHALL be IDLE, ADDR, DATA; exactly one read transaction outstanding at a time.
REQ-012 IDLE: if any ARVALID_Mx=1, arbiter SHALL pick a winner g, assert ARREADY_Mg=1 that cycle, latch g and its AR payload, go to ADDR.
REQ-013 ADDR: ARVALID_S=1 with latched payload, ARID_S={4'(g), latched ARID}; on ARVALID_S&ARREADY_S go to DATA; payload stable until handshake.
REQ-014 Request-to-ARVALID_S latency SHALL be exactly 1 cycle.
REQ-015 DATA: RVALID_Mg=RVALID_S, RREADY_S=RREADY_Mg, RDATA_Mg/RRESP_Mg/RLAST_Mg pass through, RID_Mg=RID_S[3:0]; zero added latency.
REQ-016 DATA exit: on RVALID_S&RREADY_S&RLAST_S go to IDLE and record g as last_grant; new request may be accepted the following cycle.
REQ-017 Beat counter (4-bit) SHALL count accepted R beats; if RLAST_S arrives with count != latched ARLEN, RRESP_Mg SHALL be forced to 2'b10 (SLVERR) on that beat.
REQ-018 Non-granted master SHALL see ARREADY=0, RVALID=0, RDATA=0, RLAST=0, RRESP=0 at all times.
REQ-019 ARREADY_Mx SHALL be 0 in ADDR and DATA; RREADY_S=0 outside DATA; ARVALID_S=0 outside ADDR.
REQ-020 Simultaneous ARVALID_M0&ARVALID_M1 in IDLE: winner per REQ-024; loser keeps ARVALID and is served next.

Reset
REQ-021 ARESETn=0 sampled at edge SHALL force IDLE, last_grant=M1, beat counter=0, latched payload=0, regardless of current state.
REQ-022 During/after reset all outputs SHALL be 0; a mid-burst reset abandons the transaction without further R routing.

Configuration
REQ-023 Macro AXI_ARB_RR_EN SHALL select arbitration policy.
REQ-024 Defined: round-robin, tie grants master != last_grant (M0 first after reset); undefined: fixed priority, M0 always wins ties.

Structure
REQ-025 Package axi_arb_pkg SHALL hold state enum (IDLE/ADDR/DATA), master index type, ARID_S prefix width constant, SLVERR constant.
REQ-026 Sub-module arb_rr2 SHALL implement the 2-way pick (req[1:0], last_grant -> grant), policy per AXI_ARB_RR_EN.

Verification
REQ-027 M0 alone reads 0x0000_0010, ARLEN=0 -> ARVALID_S cycle+1, ARID_S=8'h00, single beat to M0, back to IDLE.
REQ-028 M1 ARID=1 reads 0x0001_0000, ARLEN=3 -> ARID_S=8'h11, 4 beats routed to M1, RID_M1=1, M0 sees RVALID=0 throughout.
REQ-029 Both request same cycle, RR enabled, after reset -> M0 then M1; repeated 4 times -> strict alternation; RR disabled -> M0 every tie.
REQ-030 ARREADY_S held 0 for 5 cycles -> ARVALID_S and payload stable, both ARREADY_Mx=0.
REQ-031 ARLEN=3 with RLAST_S on beat 2 -> that beat RRESP_Mg=2'b10, FSM returns to IDLE.
REQ-032 ARESETn low mid-DATA -> next cycle IDLE, all outputs 0, fresh M0 request granted normally.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI read arbiter.
// Contents: bus widths, state enum, master index type, AR payload struct,
// ARID_S prefix width and the SLVERR response code.
package axi_arb_pkg;

  localparam int unsigned ID_W       = 4;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LEN_W      = 4;
  localparam int unsigned SIZE_W     = 3;
  localparam int unsigned BURST_W    = 2;
  localparam int unsigned RESP_W     = 2;
  localparam int unsigned ARID_PFX_W = 4;
  localparam int unsigned SID_W      = ARID_PFX_W + ID_W;

  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef logic [0:0] mst_idx_t;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } ar_payload_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way request picker.
// Ports: i_req[1:0] request vector, i_last_grant master that finished last,
//        o_grant_c index of the chosen master (combinational, valid when i_req != 0).
// Macro AXI_ARB_RR_EN: defined -> round-robin on ties, undefined -> M0 wins ties.
module arb_rr2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant_c
);

`ifdef AXI_ARB_RR_EN
  // Tie goes to the master that did not win last time.
  assign o_grant_c = (i_req == 2'b11) ? ~i_last_grant : i_req[1];
`else
  logic w_unused_last;
  assign w_unused_last = i_last_grant;
  // M1 only when it requests alone.
  assign o_grant_c = i_req[1] & ~i_req[0];
`endif

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master to one-slave AXI read arbiter, one transaction outstanding.
// Ports: ACLK/ARESETn (sync active-low); AR*_M0/1 master address channels;
//        R*_M0/1 routed read data; AR*_S / R*_S slave side. ARID_S carries
//        {master index, master ARID}. Tie policy selected by AXI_ARB_RR_EN.
module axi_read_arbiter
  import axi_arb_pkg::*;
(
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_W-1:0]     ARID_M0,
  input  logic [ADDR_W-1:0]   ARADDR_M0,
  input  logic [LEN_W-1:0]    ARLEN_M0,
  input  logic [SIZE_W-1:0]   ARSIZE_M0,
  input  logic [BURST_W-1:0]  ARBURST_M0,
  input  logic                ARVALID_M0,
  output logic                ARREADY_M0,
  input  logic [ID_W-1:0]     ARID_M1,
  input  logic [ADDR_W-1:0]   ARADDR_M1,
  input  logic [LEN_W-1:0]    ARLEN_M1,
  input  logic [SIZE_W-1:0]   ARSIZE_M1,
  input  logic [BURST_W-1:0]  ARBURST_M1,
  input  logic                ARVALID_M1,
  output logic                ARREADY_M1,
  output logic [ID_W-1:0]     RID_M0,
  output logic [DATA_W-1:0]   RDATA_M0,
  output logic [RESP_W-1:0]   RRESP_M0,
  output logic                RLAST_M0,
  output logic                RVALID_M0,
  input  logic                RREADY_M0,
  output logic [ID_W-1:0]     RID_M1,
  output logic [DATA_W-1:0]   RDATA_M1,
  output logic [RESP_W-1:0]   RRESP_M1,
  output logic                RLAST_M1,
  output logic                RVALID_M1,
  input  logic                RREADY_M1,
  output logic [SID_W-1:0]    ARID_S,
  output logic [ADDR_W-1:0]   ARADDR_S,
  output logic [LEN_W-1:0]    ARLEN_S,
  output logic [SIZE_W-1:0]   ARSIZE_S,
  output logic [BURST_W-1:0]  ARBURST_S,
  output logic                ARVALID_S,
  input  logic                ARREADY_S,
  input  logic [SID_W-1:0]    RID_S,
  input  logic [DATA_W-1:0]   RDATA_S,
  input  logic [RESP_W-1:0]   RRESP_S,
  input  logic                RLAST_S,
  input  logic                RVALID_S,
  output logic                RREADY_S
);

  arb_state_t        r_state, w_state_nxt;
  mst_idx_t          r_grant, r_last_grant;
  ar_payload_t       r_ar, w_ar_m0, w_ar_m1;
  logic [LEN_W-1:0]  r_beats;
  logic [1:0]        w_req;
  logic              w_pick, w_live, w_accept, w_data, w_rready_g, w_r_hs;
  logic              w_to_m0, w_to_m1, w_len_err, w_unused_rid;
  logic [RESP_W-1:0] w_rresp;

  // All outputs are held at zero while reset is asserted.
  assign w_live  = ARESETn;
  assign w_req   = {ARVALID_M1, ARVALID_M0};
  assign w_ar_m0 = {ARID_M0, ARADDR_M0, ARLEN_M0, ARSIZE_M0, ARBURST_M0};
  assign w_ar_m1 = {ARID_M1, ARADDR_M1, ARLEN_M1, ARSIZE_M1, ARBURST_M1};

  arb_rr2 u_arb (
    .i_req       (w_req),
    .i_last_grant(r_last_grant[0]),
    .o_grant_c   (w_pick)
  );

  assign w_accept   = w_live && (r_state == IDLE) && (|w_req);
  assign w_data     = w_live && (r_state == DATA);
  assign w_rready_g = r_grant[0] ? RREADY_M1 : RREADY_M0;
  assign w_r_hs     = w_data && RVALID_S && w_rready_g;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = ADDR;
      ADDR:    if (ARREADY_S) w_state_nxt = DATA;
      DATA:    if (w_r_hs && RLAST_S) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Grant, latched payload, beat counter and last-grant history.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_grant      <= '0;
      r_last_grant <= mst_idx_t'(1);
      r_ar         <= '0;
      r_beats      <= '0;
    end else begin
      if (w_accept) begin
        r_grant <= w_pick;
        r_ar    <= w_pick ? w_ar_m1 : w_ar_m0;
        r_beats <= '0;
      end else if (w_r_hs) begin
        r_beats <= r_beats + LEN_W'(1);
      end
      if (w_r_hs && RLAST_S) r_last_grant <= r_grant;
    end
  end

  // Address channel.
  assign ARREADY_M0 = w_accept && !w_pick;
  assign ARREADY_M1 = w_accept && w_pick;
  assign ARVALID_S  = w_live && (r_state == ADDR);
  assign ARID_S     = w_live ? {ARID_PFX_W'(r_grant), r_ar.id} : '0;
  assign ARADDR_S   = w_live ? r_ar.addr  : '0;
  assign ARLEN_S    = w_live ? r_ar.len   : '0;
  assign ARSIZE_S   = w_live ? r_ar.size  : '0;
  assign ARBURST_S  = w_live ? r_ar.burst : '0;

  // A last beat that arrives early or late is flagged as SLVERR.
  assign w_len_err = RVALID_S && RLAST_S && (r_beats != r_ar.len);
  assign w_rresp   = w_len_err ? RESP_SLVERR : RRESP_S;

  // Read data routing; the non-granted master sees all zeros.
  assign RREADY_S  = w_data && w_rready_g;
  assign w_to_m0   = w_data && !r_grant[0];
  assign w_to_m1   = w_data && r_grant[0];

  assign RVALID_M0 = w_to_m0 && RVALID_S;
  assign RLAST_M0  = w_to_m0 && RLAST_S;
  assign RDATA_M0  = w_to_m0 ? RDATA_S : '0;
  assign RRESP_M0  = w_to_m0 ? w_rresp : '0;
  assign RID_M0    = w_to_m0 ? RID_S[ID_W-1:0] : '0;

  assign RVALID_M1 = w_to_m1 && RVALID_S;
  assign RLAST_M1  = w_to_m1 && RLAST_S;
  assign RDATA_M1  = w_to_m1 ? RDATA_S : '0;
  assign RRESP_M1  = w_to_m1 ? w_rresp : '0;
  assign RID_M1    = w_to_m1 ? RID_S[ID_W-1:0] : '0;

  // Routing prefix of RID_S is implied by the single outstanding grant.
  assign w_unused_rid = ^RID_S[SID_W-1:ID_W];

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: directed scenarios plus random
// traffic checked against a transaction-level grant/response model.
module tb_axi_read_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [3:0]  arid    [2];
  logic [31:0] araddr  [2];
  logic [3:0]  arlen   [2];
  logic [2:0]  arsize  [2];
  logic [1:0]  arburst [2];
  logic        arvalid [2];
  logic        arready_m [2];
  logic [3:0]  rid_m   [2];
  logic [31:0] rdata_m [2];
  logic [1:0]  rresp_m [2];
  logic        rlast_m [2];
  logic        rvalid_m[2];
  logic        rready_m[2];
  logic [7:0]  arid_s;
  logic [31:0] araddr_s;
  logic [3:0]  arlen_s;
  logic [2:0]  arsize_s;
  logic [1:0]  arburst_s;
  logic        arvalid_s;
  logic        ARREADY_S = 1'b0;
  logic [7:0]  RID_S = '0;
  logic [31:0] RDATA_S = '0;
  logic [1:0]  RRESP_S = '0;
  logic        RLAST_S = 1'b0;
  logic        RVALID_S = 1'b0;
  logic        rready_s;

  int total = 0;
  int bad   = 0;
  bit last_g = 1'b1;
  bit seq_g  [4];

  always #5 ACLK = ~ACLK;

  axi_read_arbiter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID_M0(arid[0]), .ARADDR_M0(araddr[0]), .ARLEN_M0(arlen[0]),
    .ARSIZE_M0(arsize[0]), .ARBURST_M0(arburst[0]), .ARVALID_M0(arvalid[0]),
    .ARREADY_M0(arready_m[0]),
    .ARID_M1(arid[1]), .ARADDR_M1(araddr[1]), .ARLEN_M1(arlen[1]),
    .ARSIZE_M1(arsize[1]), .ARBURST_M1(arburst[1]), .ARVALID_M1(arvalid[1]),
    .ARREADY_M1(arready_m[1]),
    .RID_M0(rid_m[0]), .RDATA_M0(rdata_m[0]), .RRESP_M0(rresp_m[0]),
    .RLAST_M0(rlast_m[0]), .RVALID_M0(rvalid_m[0]), .RREADY_M0(rready_m[0]),
    .RID_M1(rid_m[1]), .RDATA_M1(rdata_m[1]), .RRESP_M1(rresp_m[1]),
    .RLAST_M1(rlast_m[1]), .RVALID_M1(rvalid_m[1]), .RREADY_M1(rready_m[1]),
    .ARID_S(arid_s), .ARADDR_S(araddr_s), .ARLEN_S(arlen_s), .ARSIZE_S(arsize_s),
    .ARBURST_S(arburst_s), .ARVALID_S(arvalid_s), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(rready_s)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: a lone requester wins; a tie goes by policy.
  function automatic bit model_pick(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef AXI_ARB_RR_EN
      return ~last_g;
`else
      return 1'b0;
`endif
    end
    return r1 & ~r0;
  endfunction

  task automatic set_req(input bit m, input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len);
    arid[m]    = id;
    araddr[m]  = addr;
    arlen[m]   = len;
    arsize[m]  = 3'($urandom_range(0, 7));
    arburst[m] = 2'($urandom_range(0, 3));
    arvalid[m] = 1'b1;
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    last_g  = 1'b1;
  endtask

  // Serve one transaction starting in an IDLE cycle with requests already driven.
  // short_b ends the burst one beat early; ar_stall holds ARREADY_S low.
  task automatic do_txn(input bit short_b, input int ar_stall, output bit g_out);
    bit g, ng, lst;
    int nb;
    logic [31:0] d;
    logic [1:0]  rs, er;
    g  = model_pick(arvalid[0], arvalid[1]);
    ng = ~g;
    nb = (short_b && arlen[g] != 4'd0) ? int'(arlen[g]) : int'(arlen[g]) + 1;
    #2;
    check("arready_win", 64'(arready_m[g]), 64'd1);
    check("arready_lose", 64'(arready_m[ng]), 64'd0);
    check("arvalid_s_idle", 64'(arvalid_s), 64'd0);
    tick();
    arvalid[g] = 1'b0;
    #2;
    check("arvalid_s", 64'(arvalid_s), 64'd1);
    check("arid_s", 64'(arid_s), 64'({4'(g), arid[g]}));
    check("araddr_s", 64'(araddr_s), 64'(araddr[g]));
    check("arlen_s", 64'(arlen_s), 64'(arlen[g]));
    check("arsize_s", 64'({arsize_s, arburst_s}), 64'({arsize[g], arburst[g]}));
    check("arready_addr", 64'({arready_m[1], arready_m[0]}), 64'd0);
    for (int s = 0; s < ar_stall; s++) begin
      tick();
      #2;
      check("stall_arvalid_s", 64'(arvalid_s), 64'd1);
      check("stall_araddr_s", 64'(araddr_s), 64'(araddr[g]));
      check("stall_arid_s", 64'(arid_s), 64'({4'(g), arid[g]}));
      check("stall_arready", 64'({arready_m[1], arready_m[0]}), 64'd0);
      check("stall_rready_s", 64'(rready_s), 64'd0);
    end
    ARREADY_S = 1'b1;
    tick();
    ARREADY_S = 1'b0;
    for (int b = 0; b < nb; b++) begin
      lst = (b == nb - 1);
      d   = $urandom;
      rs  = 2'($urandom_range(0, 3));
      RVALID_S = 1'b1;
      RDATA_S  = d;
      RRESP_S  = rs;
      RLAST_S  = lst;
      RID_S    = {4'(g), arid[g]};
      if ($urandom_range(0, 2) == 0) begin
        rready_m[g] = 1'b0;
        #2;
        check("rvalid_hold", 64'(rvalid_m[g]), 64'd1);
        check("rready_s_hold", 64'(rready_s), 64'd0);
        tick();
      end
      rready_m[g] = 1'b1;
      er = (lst && b != int'(arlen[g])) ? 2'b10 : rs;
      #2;
      check("arvalid_s_data", 64'(arvalid_s), 64'd0);
      check("rvalid_g", 64'(rvalid_m[g]), 64'd1);
      check("rdata_g", 64'(rdata_m[g]), 64'(d));
      check("rid_g", 64'(rid_m[g]), 64'(arid[g]));
      check("rlast_g", 64'(rlast_m[g]), 64'(lst));
      check("rresp_g", 64'(rresp_m[g]), 64'(er));
      check("rready_s", 64'(rready_s), 64'd1);
      check("other_r", 64'({rvalid_m[ng], rlast_m[ng], rresp_m[ng], rdata_m[ng]}), 64'd0);
      check("arready_data", 64'({arready_m[1], arready_m[0]}), 64'd0);
      tick();
    end
    RVALID_S    = 1'b0;
    RLAST_S     = 1'b0;
    rready_m[g] = 1'b0;
    last_g      = g;
    g_out       = g;
    #2;
    check("post_arvalid_s", 64'(arvalid_s), 64'd0);
    check("post_rready_s", 64'(rready_s), 64'd0);
  endtask

  initial begin
    bit g;
    bit w;
    for (int m = 0; m < 2; m++) begin
      arid[m] = '0; araddr[m] = '0; arlen[m] = '0; arsize[m] = '0;
      arburst[m] = '0; arvalid[m] = 1'b0; rready_m[m] = 1'b0;
    end

    // Reset: outputs quiet even with a request pending.
    arvalid[0] = 1'b1;
    tick();
    tick();
    #2;
    check("rst_arready0", 64'(arready_m[0]), 64'd0);
    check("rst_arvalid_s", 64'(arvalid_s), 64'd0);
    check("rst_payload", 64'({arid_s, araddr_s}), 64'd0);
    arvalid[0] = 1'b0;
    ARESETn = 1'b1;
    last_g  = 1'b1;
    tick();
    #2;
    check("idle_arready", 64'({arready_m[1], arready_m[0]}), 64'd0);
    check("idle_outputs", 64'({arvalid_s, rready_s, rvalid_m[0], rvalid_m[1]}), 64'd0);

    // M0 single beat.
    set_req(1'b0, 4'h0, 32'h0000_0010, 4'd0);
    do_txn(1'b0, 0, g);
    check("m0_single_arid", 64'(g), 64'd0);

    // M1 four-beat burst with ARID 1.
    set_req(1'b1, 4'h1, 32'h0001_0000, 4'd3);
    do_txn(1'b0, 0, g);

    // Slave holds off address acceptance for 5 cycles.
    set_req(1'b0, 4'($urandom_range(0, 15)), $urandom, 4'd1);
    do_txn(1'b0, 5, g);

    // Early RLAST on ARLEN=3 burst.
    set_req(1'b1, 4'($urandom_range(0, 15)), $urandom, 4'd3);
    do_txn(1'b1, 0, g);

    // Ties right after reset, winner re-requests immediately each time.
    do_reset();
    set_req(1'b0, 4'h2, $urandom, 4'($urandom_range(0, 2)));
    set_req(1'b1, 4'h3, $urandom, 4'($urandom_range(0, 2)));
    for (int k = 0; k < 4; k++) begin
      do_txn(1'b0, 0, w);
      seq_g[k] = w;
      set_req(w, arid[w], $urandom, arlen[w]);
    end
    for (int k = 0; k < 4; k++) begin
`ifdef AXI_ARB_RR_EN
      check("tie_order", 64'(seq_g[k]), 64'(k % 2));
`else
      check("tie_order", 64'(seq_g[k]), 64'd0);
`endif
    end
    for (int j = 0; j < 2; j++)
      if (arvalid[0] || arvalid[1]) do_txn(1'b0, 0, w);

    // Reset in the middle of a burst.
    set_req(1'b0, 4'h5, $urandom, 4'd2);
    #2;
    check("mid_arready", 64'(arready_m[0]), 64'd1);
    tick();
    arvalid[0] = 1'b0;
    ARREADY_S  = 1'b1;
    tick();
    ARREADY_S  = 1'b0;
    RVALID_S   = 1'b1;
    RDATA_S    = 32'hA5A5_0001;
    RID_S      = 8'h05;
    rready_m[0] = 1'b1;
    #2;
    check("mid_rvalid", 64'(rvalid_m[0]), 64'd1);
    ARESETn = 1'b0;
    #1;
    check("rst_rvalid", 64'(rvalid_m[0]), 64'd0);
    check("rst_rready_s", 64'(rready_s), 64'd0);
    tick();
    ARESETn = 1'b1;
    last_g  = 1'b1;
    #2;
    check("after_rst_r", 64'({rvalid_m[0], rlast_m[0], rdata_m[0]}), 64'd0);
    check("after_rst_s", 64'({arvalid_s, rready_s, arid_s, araddr_s}), 64'd0);
    RVALID_S    = 1'b0;
    rready_m[0] = 1'b0;
    set_req(1'b0, 4'h6, $urandom, 4'd1);
    do_txn(1'b0, 0, g);

    // Random traffic.
    for (int k = 0; k < 8; k++) begin
      int req;
      req = $urandom_range(1, 3);
      if (req[0]) set_req(1'b0, 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 6)));
      if (req[1]) set_req(1'b1, 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 6)));
      for (int j = 0; j < 2; j++)
        if (arvalid[0] || arvalid[1])
          do_txn(1'($urandom_range(0, 3) == 0), $urandom_range(0, 2), w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
